button_conditioner: RTL

- Conditions raw push-button inputs before they reach the turn-signal FSM and any other button-driven logic.
- Per channel: synchronises the asynchronous board input, then debounces it with a consecutive-cycle counter.
- Outputs per channel: a clean level, plus single-cycle press and release pulses.
- Runs on the 50 MHz board clock. The clean levels are stable for many ms, so slower-clock consumers may sample them directly.

---
 rtl/button_conditioner.sv | 95 +++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel two-flop synchroniser, consecutive-cycle debounce, level plus press/release pulses.
// Define BTN_AUTO_REPEAT_EN to add auto-repeat press pulses while a button is held.
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW_IN   = 1'b1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 16777215 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("button_conditioner: illegal parameter value");
    end

    logic [N_BTN-1:0]         r_sync1, r_sync2;
    logic [N_BTN-1:0][CW-1:0] r_cnt;
    logic [N_BTN-1:0]         r_level, r_press, r_release;
    logic [N_BTN-1:0]         w_toggle, w_rep;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw ^ {N_BTN{ACTIVE_LOW_IN}};
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_toggle = '0;
        for (int i = 0; i < N_BTN; i++)
            w_toggle[i] = (r_sync2[i] != r_level[i]) && (r_cnt[i] == CNT_MAX);
    end

    // Any sample agreeing with the current level restarts the count.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_cnt     <= '0;
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++)
                r_cnt[i] <= (r_sync2[i] == r_level[i] || w_toggle[i]) ? '0 : r_cnt[i] + 1'b1;
            r_level   <= r_level ^ w_toggle;
            r_press   <= (w_toggle & ~r_level) | w_rep;
            r_release <= w_toggle & r_level;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [N_BTN-1:0][RW-1:0] r_rc;
    logic [N_BTN-1:0]         r_rpt;
    logic [N_BTN-1:0]         w_hold;

    // r_rpt selects the period once the first repeat has fired.
    always_comb begin
        w_hold = r_level & ~w_toggle;
        w_rep  = '0;
        for (int i = 0; i < N_BTN; i++)
            w_rep[i] = w_hold[i] && (32'(r_rc[i]) + 1 == (r_rpt[i] ? REPEAT_PERIOD : REPEAT_DELAY));
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_rc  <= '0;
            r_rpt <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                r_rc[i]  <= (!w_hold[i] || w_rep[i]) ? '0 : r_rc[i] + 1'b1;
                r_rpt[i] <= w_hold[i] && (r_rpt[i] || w_rep[i]);
            end
        end
    end
`else
    assign w_rep = '0;
`endif

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
endmodule
